multicycle_main_control: RTL

//  Main control FSM for the multi-cycle MIPS datapath; producer of the 2-bit ALUOp consumed by the ALU control decoder.

---
 rtl/multicycle_ctrl_pkg.sv | 71 +++++++
 rtl/mc_ctrl_out_decode.sv | 83 ++++++++
 rtl/multicycle_main_control.sv | 99 +++++++++
 3 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control FSM.
// MULTICYCLE_ADDI_EN adds the ADDI_EX/ADDI_WB path; without it opcode 001000 is unsupported.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic opcode_supported(input logic [5:0] op);
    logic ok;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
`ifdef MULTICYCLE_ADDI_EN
      OP_ADDI: ok = 1'b1;
`else
      OP_ADDI: ok = 1'b0;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mc_ctrl_out_decode.sv
// Combinational state (+mem_ready, opcode) to datapath control word.
// MULTICYCLE_ADDI_EN enables decoding of the ADDI_EX/ADDI_WB states.
module mc_ctrl_out_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic        i_reset,
  input  logic [3:0]  i_state,
  input  logic        i_mem_ready,
  input  logic [5:0]  i_opcode,
  output ctrl_t       o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    // Reset and undefined encodings leave every enable and select low.
    if (!i_reset) begin
      case (i_state)
        S_FETCH: begin
          o_ctrl.mem_read  = 1'b1;
          o_ctrl.alu_src_b = SRCB_FOUR;
          o_ctrl.alu_op    = ALUOP_ADD;
          o_ctrl.pc_source = PCSRC_ALU;
          o_ctrl.pc_write  = i_mem_ready;
          o_ctrl.ir_write  = i_mem_ready;
        end
        S_DECODE: begin
          o_ctrl.alu_src_b  = SRCB_IMM_SL2;
          o_ctrl.alu_op     = ALUOP_ADD;
          o_ctrl.illegal_op = !opcode_supported(i_opcode);
        end
        S_MEMADR: begin
          o_ctrl.alu_src_a = 1'b1;
          o_ctrl.alu_src_b = SRCB_IMM;
          o_ctrl.alu_op    = ALUOP_ADD;
        end
        S_MEMRD: begin
          o_ctrl.iord     = 1'b1;
          o_ctrl.mem_read = 1'b1;
        end
        S_MEMWB: begin
          o_ctrl.mem_to_reg = 1'b1;
          o_ctrl.reg_write  = 1'b1;
        end
        S_MEMWR: begin
          o_ctrl.iord      = 1'b1;
          o_ctrl.mem_write = 1'b1;
        end
        S_RTYPE_EX: begin
          o_ctrl.alu_src_a = 1'b1;
          o_ctrl.alu_src_b = SRCB_REGB;
          o_ctrl.alu_op    = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          o_ctrl.reg_dst   = 1'b1;
          o_ctrl.reg_write = 1'b1;
        end
        S_BRANCH: begin
          o_ctrl.alu_src_a     = 1'b1;
          o_ctrl.alu_src_b     = SRCB_REGB;
          o_ctrl.alu_op        = ALUOP_SUB;
          o_ctrl.pc_write_cond = 1'b1;
          o_ctrl.pc_source     = PCSRC_ALUOUT;
        end
        S_JUMP: begin
          o_ctrl.pc_write  = 1'b1;
          o_ctrl.pc_source = PCSRC_JUMP;
        end
`ifdef MULTICYCLE_ADDI_EN
        S_ADDI_EX: begin
          o_ctrl.alu_src_a = 1'b1;
          o_ctrl.alu_src_b = SRCB_IMM;
          o_ctrl.alu_op    = ALUOP_ADD;
        end
        S_ADDI_WB: begin
          o_ctrl.reg_write = 1'b1;
        end
`endif
        default: o_ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multi-cycle MIPS datapath: state register and next-state logic.
// MULTICYCLE_ADDI_EN adds the ADDI_EX -> ADDI_WB sequence for opcode 001000.
module multicycle_main_control
  import multicycle_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next_state;
  ctrl_t              w_ctrl;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  // Unlisted encodings fall through to FETCH.
  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH:  w_next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_RTYPE:     w_next_state = S_RTYPE_EX;
          OP_BEQ:       w_next_state = S_BRANCH;
          OP_J:         w_next_state = S_JUMP;
`ifdef MULTICYCLE_ADDI_EN
          OP_ADDI:      w_next_state = S_ADDI_EX;
`endif
          default:      w_next_state = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW)      w_next_state = S_MEMRD;
        else if (opcode == OP_SW) w_next_state = S_MEMWR;
        else                      w_next_state = S_FETCH;
      end
      S_MEMRD:    w_next_state = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:    w_next_state = S_FETCH;
      S_MEMWR:    w_next_state = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPE_EX: w_next_state = S_ALUWB;
      S_ALUWB:    w_next_state = S_FETCH;
      S_BRANCH:   w_next_state = S_FETCH;
      S_JUMP:     w_next_state = S_FETCH;
`ifdef MULTICYCLE_ADDI_EN
      S_ADDI_EX:  w_next_state = S_ADDI_WB;
      S_ADDI_WB:  w_next_state = S_FETCH;
`endif
      default:    w_next_state = S_FETCH;
    endcase
  end

  mc_ctrl_out_decode u_out_decode (
    .i_reset     (reset),
    .i_state     (r_state),
    .i_mem_ready (mem_ready),
    .i_opcode    (opcode),
    .o_ctrl      (w_ctrl)
  );

  assign pc_write      = w_ctrl.pc_write;
  assign pc_write_cond = w_ctrl.pc_write_cond;
  assign iord          = w_ctrl.iord;
  assign mem_read      = w_ctrl.mem_read;
  assign mem_write     = w_ctrl.mem_write;
  assign ir_write      = w_ctrl.ir_write;
  assign mem_to_reg    = w_ctrl.mem_to_reg;
  assign reg_dst       = w_ctrl.reg_dst;
  assign reg_write     = w_ctrl.reg_write;
  assign alu_src_a     = w_ctrl.alu_src_a;
  assign alu_src_b     = w_ctrl.alu_src_b;
  assign alu_op        = w_ctrl.alu_op;
  assign pc_source     = w_ctrl.pc_source;
  assign illegal_op    = w_ctrl.illegal_op;
  assign state         = r_state;

endmodule
